vecmac_seq_ctrl: RTL
====================

// Module: vecmac_seq_ctrl
// PURPOSE
//  Sequencer for the mul4x8x8_wallace 4-lane int8 dot-product unit.
//  - Accepts a command giving a vector length N in 32-bit words, then streams N operand word pairs into the multiplier.
//  - Accumulates the N returned 18-bit partial sums into one wide result and returns it over a valid/ready port.
//  - Sits between the operand fetch path and the multiplier; the multiplier has no backpressure, so all flow control lives here.
// PARAMETERS
//  LEN_W   8    width of cmd_len; N max = 2**LEN_W-1
//  ACC_W   26   accumulator/result width; must be >= 18+LEN_W (checked by elaboration assertion)
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      synchronous reset, active-high
//  cmd_valid      in   1      command present
//  cmd_ready      out  1      command accepted when valid&ready
//  cmd_len        in   LEN_W  number of word pairs N (0 legal)
//  op_valid       in   1      operand pair present
//  op_ready       out  1      operand pair consumed when valid&ready
//  op_a, op_b     in   32     4 unsigned bytes each, lane0 = bits[7:0]
//  mul_in_valid   out  1      to multiplier in_valid
//  mul_in_a/b     out  32     to multiplier in_a/in_b
//  mul_out_valid  in   1      from multiplier out_valid
//  mul_out_sum    in   18     from multiplier out_sum
//  res_valid      out  1      result available
//  res_ready      in   1      result consumed when valid&ready
//  res_data       out  ACC_W  sum of N dot products, unsigned
//  busy           out  1      state != IDLE
//  err            out  1      sticky: mul_out_valid seen in IDLE/DONE
// BEHAVIOUR
//  Reset values: state=IDLE; cmd_ready=1; op_ready=0; mul_in_valid=0; mul_in_a/b=0; res_valid=0; res_data=0; busy=0; err=0. Counters and accumulator are cleared.
//  The multiplier is reset by the same event; the top level drives its rst_n with ~rst.
//  FSM states: IDLE, ISSUE, DRAIN, DONE.
//  - IDLE: cmd_ready=1. On cmd fire, latch N, clear acc, issue_cnt and ret_cnt.
//    - N==0: go to DONE.
//    - otherwise: go to ISSUE.
//  - ISSUE: op_ready=1 (combinational from state only).
//    - Each op fire registers mul_in_valid=1 and mul_in_a/b=op_a/op_b on the next cycle, then issue_cnt++.
//    - mul_in_valid=0 on cycles without a fire; op_valid gaps are allowed.
//    - The fire with issue_cnt==N-1 moves to DRAIN.
//  - DRAIN: op_ready=0; wait for outstanding returns.
//  - Accumulation applies in ISSUE and DRAIN: each mul_out_valid does acc += zero-extended mul_out_sum, then ret_cnt++.
//    - The update that makes ret_cnt==N moves to DONE; this can happen from ISSUE only if N returns precede the last issue (impossible), so it occurs in DRAIN.
//  - DONE: res_valid=1 and res_data=acc, both held stable while res_ready=0; cmd_ready=0.
//    - On res fire, go to IDLE; cmd_ready rises the next cycle.
//  Latency: res_valid is asserted the cycle after the last mul_out_valid. For N==0, res_valid is asserted the cycle after cmd fire.
//  Overflow cannot occur with ACC_W >= 18+LEN_W; no saturation logic.
//  mul_out_valid in IDLE/DONE is ignored for acc and sets err. err clears only on rst.
//  Reset mid-operation: rst has priority over every other event in that cycle. All state drops to reset values the next cycle, the partial accumulator is discarded and no res_valid is produced.
// TESTING
//  1 N=1, a=0x01020304, b=0x05060708 -> one mul_in_valid pulse; res_data=70 (4*8+3*7+2*6+1*5).
//  2 N=255, all words 0xFFFFFFFF, op_valid held 1 -> 255 consecutive mul_in_valid pulses; res_data=66325500; err=0.
//  3 N=0 -> no mul_in_valid; res_valid the cycle after cmd fire; res_data=0.
//  4 N=8, random op_valid gaps, res_ready low 10 cycles -> res_data stable and equal to the model sum; cmd_ready=0 until res fire.
//  5 rst pulsed after 3 of 8 words issued -> next cycle all outputs at reset values; then N=2 cmd -> correct sum with no leftover contribution.
//  6 10000 random commands (N 0..16), back-to-back cmd_valid -> each result matches the golden FIFO; no cmd accepted while busy; err=0.

Source files
------------

// File: rtl/vecmac_seq_ctrl.sv
// Sequencer feeding a 4-lane int8 dot-product multiplier: streams N operand pairs, sums N returns.
// Result 1 cycle after last return; op/cmd/res use valid-ready, multiplier side has no backpressure.
module vecmac_seq_ctrl #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic             mul_in_valid,
  output logic [31:0]      mul_in_a,
  output logic [31:0]      mul_in_b,
  input  logic             mul_out_valid,
  input  logic [17:0]      mul_out_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             busy,
  output logic             err
);

  if (ACC_W < 18 + LEN_W) begin : g_bad_acc_w
    $error("vecmac_seq_ctrl: ACC_W must be >= 18+LEN_W");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len, issue_cnt, ret_cnt;
  logic [ACC_W-1:0]   acc;
  logic               cmd_fire, op_fire, acc_en, stray_ret;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign op_fire   = op_valid & op_ready;
  // Returns only count while a vector is in flight; anything else is a protocol error.
  assign acc_en    = mul_out_valid & ((state == ISSUE) | (state == DRAIN));
  assign stray_ret = mul_out_valid & ((state == IDLE) | (state == DONE));
  assign res_data  = acc;

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_len == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        op_ready = 1'b1;
        if (op_valid && (issue_cnt == len - ONE)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (acc_en && (ret_cnt + ONE == len)) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len          <= '0;
      issue_cnt    <= '0;
      ret_cnt      <= '0;
      acc          <= '0;
      mul_in_valid <= 1'b0;
      mul_in_a     <= '0;
      mul_in_b     <= '0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      mul_in_valid <= op_fire;
      if (cmd_fire) begin
        len       <= cmd_len;
        acc       <= '0;
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end
      if (op_fire) begin
        mul_in_a  <= op_a;
        mul_in_b  <= op_b;
        issue_cnt <= issue_cnt + ONE;
      end
      if (acc_en) begin
        acc     <= acc + {{(ACC_W-18){1'b0}}, mul_out_sum};
        ret_cnt <= ret_cnt + ONE;
      end
      if (stray_ret) err <= 1'b1;
    end
  end

endmodule
